// File: rtl/booth_shift_reg.sv
// Booth multiplier-operand shift register: radix-2/4 window, trimmed
// step counter and registered done flag for early termination.
module booth_shift_reg #(
    parameter int W    = 8,
    parameter bit TRIM = 1'b1,
    localparam int CW  = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld,
    input  logic          sft,
    input  logic          mode,
    input  logic [W-1:0]  data_in,
    input  logic [1:0]    s_in,
    output logic [W-1:0]  data_out,
    output logic          q_m1,
    output logic [2:0]    booth_bits,
    output logic [CW-1:0] sig_width,
    output logic [CW-1:0] cnt,
    output logic          done
);

    logic [W-1:0]  data_q, data_d;
    logic          qm1_q, qm1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          mode_q, mode_d;
    logic          loaded_q, loaded_d;

    logic [CW-1:0] sig_w;
    logic [CW-1:0] s_sel;
    logic [CW:0]   s_plus1;
    logic [CW-1:0] steps;
    logic [W:0]    r2_cat;
    logic [W+1:0]  r4_cat;
    logic          step_en;

    // Highest bit that differs from the sign bit sets the minimal width.
    always_comb begin
        sig_w = CW'(1);
        for (int i = 0; i < W - 1; i++) begin
            if (data_in[i] != data_in[W-1]) begin
                sig_w = CW'(i + 2);
            end
        end
    end

    assign s_sel   = TRIM ? sig_w : CW'(W);
    assign s_plus1 = {1'b0, s_sel} + {{CW{1'b0}}, 1'b1};
    assign steps   = mode ? s_plus1[CW:1] : s_sel;

    assign r2_cat  = {s_in[1], data_q};
    assign r4_cat  = {s_in, data_q};
    assign step_en = sft && loaded_q && (cnt_q != '0);

    always_comb begin
        data_d   = data_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        mode_d   = mode_q;
        loaded_d = loaded_q;
        if (clr) begin
            data_d   = '0;
            qm1_d    = 1'b0;
            cnt_d    = '0;
            done_d   = 1'b0;
            mode_d   = 1'b0;
            loaded_d = 1'b0;
        end else if (ld) begin
            data_d   = data_in;
            qm1_d    = 1'b0;
            cnt_d    = steps;
            done_d   = (steps == '0);
            mode_d   = mode;
            loaded_d = 1'b1;
        end else if (step_en) begin
            if (mode_q) begin
                data_d = r4_cat[W+1:2];
                qm1_d  = data_q[1];
            end else begin
                data_d = r2_cat[W:1];
                qm1_d  = data_q[0];
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            loaded_q <= loaded_d;
        end
    end

    assign data_out   = data_q;
    assign q_m1       = qm1_q;
    assign cnt        = cnt_q;
    assign done       = done_q;
    assign sig_width  = sig_w;
    assign booth_bits = mode_q ? {data_q[1], data_q[0], qm1_q}
                               : {1'b0, data_q[0], qm1_q};

endmodule
